// File: rtl/piece_queue_if.sv
// piece_queue_if: randomizer/game-FSM handshake bundle for the piece queue
interface piece_queue_if;
  logic [2:0] rand_in_i;
  logic       req_i;
  logic       flush_i;
  logic [2:0] piece_o;
  logic [2:0] next_piece_o;
  logic       piece_valid_o;
  logic [2:0] count_o;
  modport master (output rand_in_i, req_i, flush_i, input piece_o, next_piece_o, piece_valid_o, count_o);
  modport slave (input rand_in_i, req_i, flush_i, output piece_o, next_piece_o, piece_valid_o, count_o);
endinterface

// File: rtl/piece_queue.sv
// piece_queue: buffered upcoming-piece FIFO with preview; optional 7-bag fairness
// enabled by defining PIECE_QUEUE_BAG_EN.
module piece_queue #(
  parameter int DEPTH      = 4,
  parameter int MAX_REJECT = 8
) (
  input logic           clk,
  input logic           rst_n,
  piece_queue_if.slave  bus
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [2:0] fifo_q [DEPTH];
  logic [2:0] fifo_d [DEPTH];
  logic [2:0] count_q, count_d, widx, push_id;
  logic [3:0] rej_q, rej_d;
  logic [0:0] state;
  logic       pop, push;
  assign state = count_q < 3'(DEPTH) ? FILL : FULL;
  assign pop   = bus.req_i && count_q != 3'd0;
  assign widx  = pop ? count_q - 3'd1 : count_q;
`ifdef PIECE_QUEUE_BAG_EN
  logic [6:0] mask_q, mask_d, mask_set;
  logic [7:0] taken, onehot;
  logic [2:0] low_free;
  logic       fallback, accept;
  // ID 0 is treated as permanently taken so one lookup covers validity and the bag
  assign taken    = {mask_q, 1'b1};
  assign fallback = state == FILL && rej_q == 4'(MAX_REJECT);
  assign accept   = state == FILL && !taken[bus.rand_in_i];
  assign push     = fallback || accept;
  assign push_id  = fallback ? low_free : bus.rand_in_i;
  assign onehot   = 8'd1 << push_id;
  assign mask_set = mask_q | onehot[7:1];
  always_comb begin
    low_free = 3'd0;
    for (int k = 7; k >= 1; k--) low_free = !mask_q[k-1] ? 3'(k) : low_free;
  end
  assign mask_d = bus.flush_i ? 7'd0 : !push ? mask_q : &mask_set ? 7'd0 : mask_set;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mask_q <= 7'd0;
    else mask_q <= mask_d;
`else
  assign push    = state == FILL && bus.rand_in_i != 3'd0;
  assign push_id = bus.rand_in_i;
`endif
  assign rej_d   = bus.flush_i || push ? 4'd0 : state == FILL ? rej_q + 4'd1 : rej_q;
  assign count_d = bus.flush_i ? 3'd0 : count_q + 3'(push) - 3'(pop);
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      fifo_d[i] = bus.flush_i ? 3'd0 :
                  (push && 3'(i) == widx) ? push_id :
                  !pop ? fifo_q[i] :
                  (i == DEPTH - 1) ? 3'd0 : fifo_q[(i + 1) % DEPTH];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 3'd0;
      rej_q   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 3'd0;
    end else begin
      count_q <= count_d;
      rej_q   <= rej_d;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end
  assign bus.piece_o       = fifo_q[0];
  assign bus.next_piece_o  = fifo_q[1];
  assign bus.piece_valid_o = count_q != 3'd0;
  assign bus.count_o       = count_q;
endmodule
